jtag_tap_slave: RTL and testbench

- Synthesizable IEEE 1149.1 TAP responder: the device-side end of the JTAG bit-bang link driven by the simulation JTAG driver over tck/tms/tdi.
- Oversamples the JTAG pins with the system clock, runs the 16-state TAP controller, and implements IR, BYPASS, IDCODE and one user data register.
- The user register hands captured and updated words to on-chip debug logic.

---
 rtl/jtag_tap_slave.sv | 195 +++++++++++++++++++
 tb/tb_jtag_tap_slave.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_slave.sv
// IEEE 1149.1 TAP responder oversampled by clk: IR, BYPASS, IDCODE, USER DR.
// Define JTAG_TAP_IDCODE_EN to build the IDCODE register and make it the reset instruction.
module jtag_tap_slave #(
  parameter int unsigned        IR_LEN        = 4,
  parameter logic [31:0]        IDCODE_VAL    = 32'h1000_0001,
  parameter int unsigned        USER_DR_LEN   = 32,
  parameter logic [IR_LEN-1:0]  USER_OPCODE   = IR_LEN'(8),
  parameter logic [IR_LEN-1:0]  IDCODE_OPCODE = IR_LEN'(1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tck,
  input  logic                   tms,
  input  logic                   tdi,
  output logic                   tdo,
  output logic                   tdo_oe,
  output logic [3:0]             tap_state,
  output logic [IR_LEN-1:0]      ir_q,
  input  logic [USER_DR_LEN-1:0] user_capture_data,
  output logic                   user_update,
  output logic [USER_DR_LEN-1:0] user_update_data
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_e;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [IR_LEN-1:0] RST_IR = IDCODE_OPCODE;
`else
  localparam logic [IR_LEN-1:0] RST_IR = '1;
`endif

  tap_e state_q, state_d;

  logic tck_s1_q, tck_s2_q, tck_p_q;
  logic tms_s1_q, tms_s2_q;
  logic tdi_s1_q, tdi_s2_q;
  logic [1:0] arm_q;
  logic armed, rise, fall;

  logic [IR_LEN-1:0]      ir_sr_q;
  logic                   bypass_q;
  logic [USER_DR_LEN-1:0] user_sr_q;
  logic [USER_DR_LEN-1:0] user_data_q;
  logic                   user_update_q;
  logic                   tdo_q;
  logic                   sel_id, sel_user, dr_lsb;

`ifdef JTAG_TAP_IDCODE_EN
  logic [31:0] id_sr_q;
  assign sel_id = (ir_q == IDCODE_OPCODE);
`else
  logic unused_id;
  assign unused_id = ^{IDCODE_VAL, IDCODE_OPCODE};
  assign sel_id = 1'b0;
`endif

  assign sel_user = (ir_q == USER_OPCODE) & ~sel_id;

  // Edges are ignored until the synchronizers hold the real pin level
  assign armed = (arm_q == 2'd3);
  assign rise  = armed & tck_s2_q & ~tck_p_q;
  assign fall  = armed & ~tck_s2_q & tck_p_q;

  // Two-flop synchronizers plus the tck edge register
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_s1_q <= 1'b0;
      tck_s2_q <= 1'b0;
      tck_p_q  <= 1'b0;
      tms_s1_q <= 1'b0;
      tms_s2_q <= 1'b0;
      tdi_s1_q <= 1'b0;
      tdi_s2_q <= 1'b0;
      arm_q    <= 2'd0;
    end else begin
      tck_s1_q <= tck;
      tck_s2_q <= tck_s1_q;
      tck_p_q  <= tck_s2_q;
      tms_s1_q <= tms;
      tms_s2_q <= tms_s1_q;
      tdi_s1_q <= tdi;
      tdi_s2_q <= tdi_s1_q;
      if (!armed) arm_q <= arm_q + 2'd1;
    end
  end

  // TAP state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= TLR;
    else     state_q <= state_d;
  end

  // TAP next state, advanced only on a detected tck rise
  always_comb begin
    state_d = state_q;
    if (rise) begin
      case (state_q)
        TLR:     state_d = tms_s2_q ? TLR    : RTI;
        RTI:     state_d = tms_s2_q ? SEL_DR : RTI;
        SEL_DR:  state_d = tms_s2_q ? SEL_IR : CAP_DR;
        CAP_DR:  state_d = tms_s2_q ? EX1_DR : SH_DR;
        SH_DR:   state_d = tms_s2_q ? EX1_DR : SH_DR;
        EX1_DR:  state_d = tms_s2_q ? UPD_DR : PAU_DR;
        PAU_DR:  state_d = tms_s2_q ? EX2_DR : PAU_DR;
        EX2_DR:  state_d = tms_s2_q ? UPD_DR : SH_DR;
        UPD_DR:  state_d = tms_s2_q ? SEL_DR : RTI;
        SEL_IR:  state_d = tms_s2_q ? TLR    : CAP_IR;
        CAP_IR:  state_d = tms_s2_q ? EX1_IR : SH_IR;
        SH_IR:   state_d = tms_s2_q ? EX1_IR : SH_IR;
        EX1_IR:  state_d = tms_s2_q ? UPD_IR : PAU_IR;
        PAU_IR:  state_d = tms_s2_q ? EX2_IR : PAU_IR;
        EX2_IR:  state_d = tms_s2_q ? UPD_IR : SH_IR;
        UPD_IR:  state_d = tms_s2_q ? SEL_DR : RTI;
        default: state_d = TLR;
      endcase
    end
  end

  // Outputs decoded from the current state
  always_comb begin
    tdo_oe = (state_q == SH_DR) || (state_q == SH_IR);
  end

  // LSB of whichever data register the instruction selects
  always_comb begin
    dr_lsb = bypass_q;
    if (sel_user) dr_lsb = user_sr_q[0];
`ifdef JTAG_TAP_IDCODE_EN
    if (sel_id) dr_lsb = id_sr_q[0];
`endif
  end

  // Capture/shift on tck rise, update on entry to Update-xR, tdo on fall
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q          <= RST_IR;
      ir_sr_q       <= '0;
      bypass_q      <= 1'b0;
      user_sr_q     <= '0;
      user_data_q   <= '0;
      user_update_q <= 1'b0;
      tdo_q         <= 1'b0;
`ifdef JTAG_TAP_IDCODE_EN
      id_sr_q       <= '0;
`endif
    end else begin
      user_update_q <= 1'b0;
      if (rise) begin
        case (state_q)
          CAP_IR: ir_sr_q <= IR_LEN'(1);
          SH_IR:  ir_sr_q <= {tdi_s2_q, ir_sr_q[IR_LEN-1:1]};
          CAP_DR: begin
            bypass_q <= 1'b0;
            if (sel_user) user_sr_q <= user_capture_data;
`ifdef JTAG_TAP_IDCODE_EN
            if (sel_id) id_sr_q <= IDCODE_VAL;
`endif
          end
          SH_DR: begin
            unique case (1'b1)
`ifdef JTAG_TAP_IDCODE_EN
              sel_id:   id_sr_q <= {tdi_s2_q, id_sr_q[31:1]};
`endif
              sel_user: user_sr_q <= {tdi_s2_q, user_sr_q[USER_DR_LEN-1:1]};
              default:  bypass_q <= tdi_s2_q;
            endcase
          end
          default: ;
        endcase
        if (state_d == TLR)    ir_q <= RST_IR;
        if (state_d == UPD_IR) ir_q <= ir_sr_q;
        if (state_d == UPD_DR && sel_user) begin
          user_update_q <= 1'b1;
          user_data_q   <= user_sr_q;
        end
      end
      if (fall) begin
        if (state_q == SH_IR) tdo_q <= ir_sr_q[0];
        if (state_q == SH_DR) tdo_q <= dr_lsb;
      end
    end
  end

  assign tap_state        = state_q;
  assign tdo              = tdo_q;
  assign user_update      = user_update_q;
  assign user_update_data = user_data_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Bench for jtag_tap_slave: bit-banged JTAG scans against a scan-level model.
// Works with and without JTAG_TAP_IDCODE_EN.
module tb_jtag_tap_slave;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tck = 1'b0;
  logic        tms = 1'b1;
  logic        tdi = 1'b0;
  logic        tdo, tdo_oe;
  logic [3:0]  tap_state;
  logic [3:0]  ir_q;
  logic [31:0] user_capture_data = '0;
  logic        user_update;
  logic [31:0] user_update_data;

  jtag_tap_slave dut (
    .clk               (clk),
    .rst               (rst),
    .tck               (tck),
    .tms               (tms),
    .tdi               (tdi),
    .tdo               (tdo),
    .tdo_oe            (tdo_oe),
    .tap_state         (tap_state),
    .ir_q              (ir_q),
    .user_capture_data (user_capture_data),
    .user_update       (user_update),
    .user_update_data  (user_update_data)
  );

  always #5 clk = ~clk;

`ifdef JTAG_TAP_IDCODE_EN
  localparam logic [3:0] RST_IR = 4'h1;
`else
  localparam logic [3:0] RST_IR = 4'hF;
`endif

  // 1149.1 graph: nibble s of G0/G1 is the successor of state s for tms=0/1
  logic [63:0] g0 = 64'hCACC_BABA_62CE_3232;
  logic [63:0] g1 = 64'hF977_89DD_417F_0155;
  logic [3:0]  exp_state;
  int n_chk = 0;
  int n_fail = 0;
  int upd_cnt = 0;

  always @(posedge clk) if (user_update === 1'b1) upd_cnt <= upd_cnt + 1;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One TCK period; returns tdo as seen just before the rise
  task automatic jtag_bit(input logic m, input logic d, output logic o);
    o = tdo;
    tms = m;
    tdi = d;
    wait_clk(4);
    tck = 1'b1;
    wait_clk(4);
    tck = 1'b0;
    wait_clk(4);
    exp_state = m ? g1[int'(exp_state)*4 +: 4] : g0[int'(exp_state)*4 +: 4];
  endtask

  task automatic goto_rti;
    logic o;
    repeat (5) jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] out);
    logic o;
    out = '0;
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
    for (int i = 0; i < 4; i++) begin
      jtag_bit(i == 3, v[i], o);
      out[i] = o;
    end
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
  endtask

  task automatic scan_dr(input int n, input logic [31:0] v, output logic [31:0] out);
    logic o;
    out = '0;
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
    for (int i = 0; i < n; i++) begin
      jtag_bit(i == n - 1, v[i], o);
      out[i] = o;
    end
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    wait_clk(3);
    rst = 1'b0;
    wait_clk(4);
    exp_state = 4'hF;
    n_chk++;
    if (tap_state !== 4'hF) begin
      n_fail++; $display("FAIL reset_state got %h want F", tap_state);
    end
    n_chk++;
    if (ir_q !== RST_IR) begin
      n_fail++; $display("FAIL reset_ir got %h want %h", ir_q, RST_IR);
    end
    n_chk++;
    if ({tdo, tdo_oe, user_update} !== 3'b000) begin
      n_fail++; $display("FAIL reset_outs got %b want 000", {tdo, tdo_oe, user_update});
    end
    n_chk++;
    if (user_update_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_udata got %h want 0", user_update_data);
    end
  endtask

  task automatic test_tlr_rti;
    logic o;
    repeat (5) jtag_bit(1'b1, 1'b0, o);
    n_chk++;
    if (tap_state !== 4'hF) begin
      n_fail++; $display("FAIL tlr got %h want F", tap_state);
    end
    jtag_bit(1'b0, 1'b0, o);
    n_chk++;
    if (tap_state !== 4'hC || tdo_oe !== 1'b0) begin
      n_fail++; $display("FAIL rti got %h/%b want C/0", tap_state, tdo_oe);
    end
  endtask

  // Rise on the pin must reach tap_state after exactly 3 clk
  task automatic test_latency;
    logic o;
    tms = 1'b1;
    wait_clk(4);
    tck = 1'b1;
    wait_clk(2);
    n_chk++;
    if (tap_state !== 4'hC) begin
      n_fail++; $display("FAIL lat_early got %h want C", tap_state);
    end
    wait_clk(1);
    n_chk++;
    if (tap_state !== 4'h7) begin
      n_fail++; $display("FAIL lat_3clk got %h want 7", tap_state);
    end
    wait_clk(1);
    tck = 1'b0;
    wait_clk(4);
    exp_state = 4'h7;
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
  endtask

  // A tck edge present across reset release must not move the FSM
  task automatic test_reset_edge;
    rst = 1'b1;
    tms = 1'b0;
    wait_clk(2);
    tck = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(8);
    n_chk++;
    if (tap_state !== 4'hF) begin
      n_fail++; $display("FAIL reset_edge got %h want F", tap_state);
    end
    tck = 1'b0;
    wait_clk(6);
    exp_state = 4'hF;
  endtask

  task automatic test_random_walk;
    logic o;
    logic m;
    for (int i = 0; i < 60; i++) begin
      m = 1'($urandom_range(0, 2) == 0);
      jtag_bit(m, 1'($urandom), o);
      n_chk++;
      if (tap_state !== exp_state ||
          tdo_oe !== (exp_state == 4'h2 || exp_state == 4'hA)) begin
        n_fail++;
        $display("FAIL walk step %0d got %h/%b want %h", i, tap_state, tdo_oe, exp_state);
      end
    end
    repeat (5) jtag_bit(1'b1, 1'($urandom), o);
    n_chk++;
    if (tap_state !== 4'hF || ir_q !== RST_IR) begin
      n_fail++; $display("FAIL walk_tlr got %h/%h want F/%h", tap_state, ir_q, RST_IR);
    end
    jtag_bit(1'b0, 1'b0, o);
  endtask

  task automatic test_ir_bypass;
    logic [3:0]  iout;
    logic [31:0] dout, din, want;
    logic [3:0]  op;
    for (int k = 0; k < 3; k++) begin
      if (k == 0) op = 4'hF;
      else begin
        do op = 4'($urandom_range(0, 15));
`ifdef JTAG_TAP_IDCODE_EN
        while (op == 4'h8 || op == 4'h1);
`else
        while (op == 4'h8);
`endif
      end
      scan_ir(op, iout);
      n_chk++;
      if (iout !== 4'b0001) begin
        n_fail++; $display("FAIL ir_capture got %b want 0001", iout);
      end
      n_chk++;
      if (ir_q !== op) begin
        n_fail++; $display("FAIL ir_update got %h want %h", ir_q, op);
      end
      din = (k == 0) ? 32'hA5 : 32'($urandom_range(0, 255));
      want = (din << 1) & 32'hFF;
      scan_dr(8, din, dout);
      n_chk++;
      if (dout !== want) begin
        n_fail++; $display("FAIL bypass ir=%h got %h want %h", op, dout, want);
      end
    end
  endtask

  task automatic test_idcode;
    logic [31:0] dout, want;
    logic [3:0]  iout;
`ifdef JTAG_TAP_IDCODE_EN
    goto_rti();
    scan_dr(32, 32'h0, dout);
    want = 32'h1000_0001;
    n_chk++;
    if (dout !== want) begin
      n_fail++; $display("FAIL idcode got %h want %h", dout, want);
    end
`else
    scan_ir(4'h1, iout);
    scan_dr(8, 32'hA5, dout);
    want = 32'h4A;
    n_chk++;
    if (dout !== want) begin
      n_fail++; $display("FAIL ir1_bypass got %h want %h", dout, want);
    end
`endif
  endtask

  task automatic test_user;
    logic [3:0]  iout;
    logic [31:0] cap, din, dout;
    int base;
    scan_ir(4'h8, iout);
    for (int k = 0; k < 4; k++) begin
      cap = (k == 0) ? 32'h1234_5678 : $urandom;
      din = (k == 0) ? 32'hDEAD_BEEF : $urandom;
      user_capture_data = cap;
      base = upd_cnt;
      scan_dr(32, din, dout);
      user_capture_data = ~cap;
      wait_clk(2);
      n_chk++;
      if (dout !== cap) begin
        n_fail++; $display("FAIL user_out got %h want %h", dout, cap);
      end
      n_chk++;
      if (upd_cnt - base !== 1) begin
        n_fail++; $display("FAIL user_pulses got %0d want 1", upd_cnt - base);
      end
      n_chk++;
      if (user_update_data !== din) begin
        n_fail++; $display("FAIL user_data got %h want %h", user_update_data, din);
      end
    end
  endtask

  task automatic test_midscan_reset;
    logic o;
    int base;
    logic [3:0] iout;
    scan_ir(4'h8, iout);
    user_capture_data = $urandom;
    base = upd_cnt;
    jtag_bit(1'b1, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
    jtag_bit(1'b0, 1'b0, o);
    for (int i = 0; i < 10; i++) jtag_bit(1'b0, 1'($urandom), o);
    rst = 1'b1;
    wait_clk(1);
    n_chk++;
    if (tap_state !== 4'hF) begin
      n_fail++; $display("FAIL mid_rst_state got %h want F", tap_state);
    end
    wait_clk(2);
    rst = 1'b0;
    wait_clk(6);
    exp_state = 4'hF;
    n_chk++;
    if (upd_cnt !== base || user_update_data !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_rst_upd got %0d/%h want %0d/0", upd_cnt, user_update_data, base);
    end
    n_chk++;
    if (ir_q !== RST_IR) begin
      n_fail++; $display("FAIL mid_rst_ir got %h want %h", ir_q, RST_IR);
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_tlr_rti();
    test_latency();
    test_reset_edge();
    goto_rti();
    test_random_walk();
    test_ir_bypass();
    test_idcode();
    test_user();
    test_midscan_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
